control_sequencer: RTL
======================

Name: control_sequencer

Overview:
Hardwired control unit that replaces bench-driven control sequencing of the DataPath. It steps a fetch/execute T-state machine, T0-T7, and drives every DataPath control strobe as one packed control vector. It supports the full instruction set, a memory-ready handshake that stretches Read/Write states, conditional branch on CON_out, and stop/halt handling. It sits beside DataPath in the CPU top level and reads the opcode back from IR.

Parameters:
OPCODE_W, 5, opcode field width (IR[31:27]).
ALUOP_W, 5, width of the alu_op output.
CTRL_W, 30, width of the ctrl vector; bit map is fixed in the package.
WAIT_EN, 1, 1 = Read/Write states hold until mem_ready; 0 = mem_ready ignored, one cycle each.

Ports:
clock  in  1  system clock, rising edge.
clear  in  1  asynchronous, active-high reset.
ir_opcode  in  OPCODE_W  IR opcode field; valid from the cycle after IRin.
CON_out  in  1  branch condition from the CON FF.
mem_ready  in  1  memory completes the current Read/Write this cycle.
stop  in  1  level request to halt at the next instruction boundary.
ctrl  out  CTRL_W  packed DataPath strobes (PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, HIin, LOin, HIout, LOout, ZHighIn, ZLowIn, CONin, InPortout, OutPortin, R15in, ZLowIn_add).
alu_op  out  ALUOP_W  ALU operation select, valid whenever ZLowIn/ZHighIn is asserted.
run  out  1  1 while executing; 0 in HALTED.
illegal  out  1  one-cycle pulse when an undefined opcode is decoded.

Behaviour:
- Reset:
  - clear=1 forces state RST asynchronously, including mid-instruction.
  - While in RST: ctrl=0, alu_op=0, illegal=0, run=1.
  - First clock edge after clear deasserts moves RST -> T0.
- Output style:
  - Moore outputs, decoded from the registered state and the latched opcode.
  - Every strobe is high for exactly the cycles its state lasts.
- Opcode latch: opcode is sampled from ir_opcode on the T2 -> T3 edge and held until the next T2.
- Fetch:
  - T0: PCout, MARin, IncPC, ZLowIn; alu_op = ADD.
  - T1: Zlowout, PCin, Read, MDRin. Holds while WAIT_EN=1 and mem_ready=0; Read and MDRin stay high through the wait.
  - T2: MDRout, IRin.
- ALU reg-reg (ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ZLowIn; alu_op = opcode.
  - T5: Zlowout, Gra, Rin.
- ALU immediate (ADDI, ANDI, ORI): same as reg-reg, but T4 uses Cout instead of Grc, Rout.
- MUL/DIV:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, ZHighIn, ZLowIn.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
- NEG/NOT:
  - T3: Grb, Rout, ZLowIn.
  - T4: Zlowout, Gra, Rin.
- LD/LDI:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ZLowIn; alu_op = ADD.
  - T5 for LDI: Zlowout, Gra, Rin; instruction ends.
  - T5 for LD: Zlowout, MARin.
  - T6 for LD: Read, MDRin; waits on mem_ready.
  - T7 for LD: MDRout, Gra, Rin.
- ST:
  - T3-T5 as LD.
  - T6: Gra, Rout, MDRin.
  - T7: Write; waits on mem_ready.
- BR:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, ZLowIn; alu_op = ADD.
  - T6: Zlowout, plus PCin only if CON_out=1. T6 is always visited, so BR takes a fixed 7 cycles.
- JR: T3: Gra, Rout, PCin.
- JAL:
  - T3: PCout, R15in.
  - T4: Gra, Rout, PCin.
- Single-cycle moves:
  - IN, T3: InPortout, Gra, Rin.
  - OUT, T3: Gra, Rout, OutPortin.
  - MFHI, T3: HIout, Gra, Rin.
  - MFLO, T3: LOout, Gra, Rin.
- NOP: T3 drives ctrl=0.
- Undefined opcode: treated as NOP, and illegal pulses during T3.
- HALT: T3 -> HALTED. HALTED drives ctrl=0 and run=0, and is exited only by clear.
- Instruction boundary (last execute state):
  - stop=1 -> HALTED.
  - Otherwise -> T0.
- stop while mem_ready is pending: the wait completes first.
- mem_ready arriving in a non-memory state is ignored.
- Cycle counts with WAIT_EN=0: ADD = 6, JR = 4, LD = 8, BR = 7, MUL = 7.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode constants: LD 00000, LDI 00001, ST 00010, ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, ADDI 01100, ANDI 01101, ORI 01110, DIV 01111, MUL 10000, NEG 10001, NOT 10010, BR 10011, JAL 10100, JR 10101, IN 10110, OUT 10111, MFLO 11000, MFHI 11001, NOP 11010, HALT 11011.
  - ctrl bit indices.
  - state encoding: RST, T0-T7, HALTED.
- Sub-module ctrl_decode: combinational (state, opcode, CON_out) -> (ctrl, alu_op, illegal).
- control_sequencer holds the state register, opcode latch and wait/stop logic.

Test Plan:
- Reset mid-instruction: assert clear during LD T6 -> ctrl=0 in the same cycle; after release, T0 asserts PCout, MARin, IncPC one edge later.
- JR, WAIT_EN=0: opcode 10101 -> PCin+Gra+Rout high in cycle 4; next cycle back in T0.
- ADD, WAIT_EN=1, mem_ready low 2 cycles in T1: Read held for 3 cycles; alu_op = 00011 in T4; total 8 cycles.
- BR with CON_out=0, then BR with CON_out=1: PCin absent in the first T6, present in the second; both take 7 cycles.
- ST with mem_ready delayed 3 cycles in T7: Write high for 4 cycles and never asserted with Read.
- stop raised during MUL T4: HIin completes in T6, then HALTED with run=0; opcode 11111 in a later run -> one-cycle illegal pulse, then T0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, the
// DataPath strobe bit map, T-state encoding and opcode classification.
package cpu_ctrl_pkg;

  localparam int OPCODE_WIDTH = 5;
  localparam int ALUOP_WIDTH  = 5;
  localparam int CTRL_WIDTH   = 30;

  typedef logic [OPCODE_WIDTH-1:0] opcode_t;
  typedef logic [ALUOP_WIDTH-1:0]  aluop_t;
  typedef logic [CTRL_WIDTH-1:0]   ctrl_t;

  // Opcode field IR[31:27]
  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_ROR  = 5'b00111;
  localparam opcode_t OP_ROL  = 5'b01000;
  localparam opcode_t OP_SHR  = 5'b01001;
  localparam opcode_t OP_SHRA = 5'b01010;
  localparam opcode_t OP_SHL  = 5'b01011;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_ANDI = 5'b01101;
  localparam opcode_t OP_ORI  = 5'b01110;
  localparam opcode_t OP_DIV  = 5'b01111;
  localparam opcode_t OP_MUL  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;
  localparam opcode_t OP_BR   = 5'b10011;
  localparam opcode_t OP_JAL  = 5'b10100;
  localparam opcode_t OP_JR   = 5'b10101;
  localparam opcode_t OP_IN   = 5'b10110;
  localparam opcode_t OP_OUT  = 5'b10111;
  localparam opcode_t OP_MFLO = 5'b11000;
  localparam opcode_t OP_MFHI = 5'b11001;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  // Bit positions of the DataPath strobes inside ctrl
  localparam int CB_PC_OUT      = 0;
  localparam int CB_ZHIGH_OUT   = 1;
  localparam int CB_ZLOW_OUT    = 2;
  localparam int CB_MDR_OUT     = 3;
  localparam int CB_MAR_IN      = 4;
  localparam int CB_PC_IN       = 5;
  localparam int CB_MDR_IN      = 6;
  localparam int CB_IR_IN       = 7;
  localparam int CB_Y_IN        = 8;
  localparam int CB_INC_PC      = 9;
  localparam int CB_READ        = 10;
  localparam int CB_WRITE       = 11;
  localparam int CB_GRA         = 12;
  localparam int CB_GRB         = 13;
  localparam int CB_GRC         = 14;
  localparam int CB_R_IN        = 15;
  localparam int CB_R_OUT       = 16;
  localparam int CB_BA_OUT      = 17;
  localparam int CB_C_OUT       = 18;
  localparam int CB_HI_IN       = 19;
  localparam int CB_LO_IN       = 20;
  localparam int CB_HI_OUT      = 21;
  localparam int CB_LO_OUT      = 22;
  localparam int CB_ZHIGH_IN    = 23;
  localparam int CB_ZLOW_IN     = 24;
  localparam int CB_CON_IN      = 25;
  localparam int CB_INPORT_OUT  = 26;
  localparam int CB_OUTPORT_IN  = 27;
  localparam int CB_R15_IN      = 28;
  localparam int CB_ZLOW_IN_ADD = 29;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALTED = 4'd9
  } state_t;

  // Instruction families that share an execute sequence
  typedef enum logic [4:0] {
    CL_ALU, CL_IMM, CL_MULDIV, CL_UNARY, CL_LD, CL_LDI, CL_ST, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT,
    CL_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:      return CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:     return CL_IMM;
      OP_MUL, OP_DIV:               return CL_MULDIV;
      OP_NEG, OP_NOT:               return CL_UNARY;
      OP_LD:                        return CL_LD;
      OP_LDI:                       return CL_LDI;
      OP_ST:                        return CL_ST;
      OP_BR:                        return CL_BR;
      OP_JR:                        return CL_JR;
      OP_JAL:                       return CL_JAL;
      OP_IN:                        return CL_IN;
      OP_OUT:                       return CL_OUT;
      OP_MFHI:                      return CL_MFHI;
      OP_MFLO:                      return CL_MFLO;
      OP_NOP:                       return CL_NOP;
      OP_HALT:                      return CL_HALT;
      default:                      return CL_ILLEGAL;
    endcase
  endfunction

  // Final execute state of each family; the instruction boundary follows it
  function automatic state_t last_state(op_class_t cl);
    case (cl)
      CL_ALU, CL_IMM, CL_LDI: return S_T5;
      CL_MULDIV, CL_BR:       return S_T6;
      CL_UNARY, CL_JAL:       return S_T4;
      CL_LD, CL_ST:           return S_T7;
      default:                return S_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer (master) and the DataPath side (slave).
//
// Memory handshake: the sequencer holds Read (T1, LD T6) or Write (ST T7)
// high and stays in that state until it samples mem_ready=1 on a rising
// clock edge; that edge completes the access and advances the state.
// mem_ready seen in any other state has no effect.
interface control_sequencer_if #(
  parameter int OPCODE_W = 5,
  parameter int ALUOP_W  = 5,
  parameter int CTRL_W   = 30
);
  logic [OPCODE_W-1:0] ir_opcode;
  logic                CON_out;
  logic                mem_ready;
  logic                stop;
  logic [CTRL_W-1:0]   ctrl;
  logic [ALUOP_W-1:0]  alu_op;
  logic                run;
  logic                illegal;

  modport master (
    input  ir_opcode, CON_out, mem_ready, stop,
    output ctrl, alu_op, run, illegal
  );

  modport slave (
    output ir_opcode, CON_out, mem_ready, stop,
    input  ctrl, alu_op, run, illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Moore output decode: maps the current T-state and latched opcode onto the
// packed DataPath strobe vector, the ALU operation and the illegal flag.
// ZLowIn_add stays low: the add used for address and PC arithmetic is
// selected through alu_op together with ZLowIn.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t  state,
  input  opcode_t opcode,
  input  logic    con_out,
  output ctrl_t   ctrl,
  output aluop_t  alu_op,
  output logic    illegal
);

  op_class_t op_class;

  assign op_class = classify(opcode);

  // Strobe decode per state and instruction family
  always_comb begin
    ctrl    = '0;
    alu_op  = '0;
    illegal = 1'b0;
    case (state)
      S_T0: begin
        ctrl[CB_PC_OUT]   = 1'b1;
        ctrl[CB_MAR_IN]   = 1'b1;
        ctrl[CB_INC_PC]   = 1'b1;
        ctrl[CB_ZLOW_IN]  = 1'b1;
        alu_op            = OP_ADD;
      end
      S_T1: begin
        ctrl[CB_ZLOW_OUT] = 1'b1;
        ctrl[CB_PC_IN]    = 1'b1;
        ctrl[CB_READ]     = 1'b1;
        ctrl[CB_MDR_IN]   = 1'b1;
      end
      S_T2: begin
        ctrl[CB_MDR_OUT]  = 1'b1;
        ctrl[CB_IR_IN]    = 1'b1;
      end
      S_T3: begin
        case (op_class)
          CL_ALU, CL_IMM: begin
            ctrl[CB_GRB] = 1'b1; ctrl[CB_R_OUT] = 1'b1; ctrl[CB_Y_IN] = 1'b1;
          end
          CL_MULDIV: begin
            ctrl[CB_GRA] = 1'b1; ctrl[CB_R_OUT] = 1'b1; ctrl[CB_Y_IN] = 1'b1;
          end
          CL_UNARY: begin
            ctrl[CB_GRB] = 1'b1; ctrl[CB_R_OUT] = 1'b1; ctrl[CB_ZLOW_IN] = 1'b1;
            alu_op = opcode;
          end
          CL_LD, CL_LDI, CL_ST: begin
            ctrl[CB_GRB] = 1'b1; ctrl[CB_BA_OUT] = 1'b1; ctrl[CB_Y_IN] = 1'b1;
          end
          CL_BR: begin
            ctrl[CB_GRA] = 1'b1; ctrl[CB_R_OUT] = 1'b1; ctrl[CB_CON_IN] = 1'b1;
          end
          CL_JR: begin
            ctrl[CB_GRA] = 1'b1; ctrl[CB_R_OUT] = 1'b1; ctrl[CB_PC_IN] = 1'b1;
          end
          CL_JAL: begin
            ctrl[CB_PC_OUT] = 1'b1; ctrl[CB_R15_IN] = 1'b1;
          end
          CL_IN: begin
            ctrl[CB_INPORT_OUT] = 1'b1; ctrl[CB_GRA] = 1'b1; ctrl[CB_R_IN] = 1'b1;
          end
          CL_OUT: begin
            ctrl[CB_GRA] = 1'b1; ctrl[CB_R_OUT] = 1'b1; ctrl[CB_OUTPORT_IN] = 1'b1;
          end
          CL_MFHI: begin
            ctrl[CB_HI_OUT] = 1'b1; ctrl[CB_GRA] = 1'b1; ctrl[CB_R_IN] = 1'b1;
          end
          CL_MFLO: begin
            ctrl[CB_LO_OUT] = 1'b1; ctrl[CB_GRA] = 1'b1; ctrl[CB_R_IN] = 1'b1;
          end
          CL_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (op_class)
          CL_ALU: begin
            ctrl[CB_GRC] = 1'b1; ctrl[CB_R_OUT] = 1'b1; ctrl[CB_ZLOW_IN] = 1'b1;
            alu_op = opcode;
          end
          CL_IMM: begin
            ctrl[CB_C_OUT] = 1'b1; ctrl[CB_ZLOW_IN] = 1'b1;
            alu_op = opcode;
          end
          CL_MULDIV: begin
            ctrl[CB_GRB] = 1'b1; ctrl[CB_R_OUT] = 1'b1;
            ctrl[CB_ZHIGH_IN] = 1'b1; ctrl[CB_ZLOW_IN] = 1'b1;
            alu_op = opcode;
          end
          CL_UNARY: begin
            ctrl[CB_ZLOW_OUT] = 1'b1; ctrl[CB_GRA] = 1'b1; ctrl[CB_R_IN] = 1'b1;
          end
          CL_LD, CL_LDI, CL_ST: begin
            ctrl[CB_C_OUT] = 1'b1; ctrl[CB_ZLOW_IN] = 1'b1;
            alu_op = OP_ADD;
          end
          CL_BR: begin
            ctrl[CB_PC_OUT] = 1'b1; ctrl[CB_Y_IN] = 1'b1;
          end
          CL_JAL: begin
            ctrl[CB_GRA] = 1'b1; ctrl[CB_R_OUT] = 1'b1; ctrl[CB_PC_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_class)
          CL_ALU, CL_IMM, CL_LDI: begin
            ctrl[CB_ZLOW_OUT] = 1'b1; ctrl[CB_GRA] = 1'b1; ctrl[CB_R_IN] = 1'b1;
          end
          CL_MULDIV: begin
            ctrl[CB_ZLOW_OUT] = 1'b1; ctrl[CB_LO_IN] = 1'b1;
          end
          CL_LD, CL_ST: begin
            ctrl[CB_ZLOW_OUT] = 1'b1; ctrl[CB_MAR_IN] = 1'b1;
          end
          CL_BR: begin
            ctrl[CB_C_OUT] = 1'b1; ctrl[CB_ZLOW_IN] = 1'b1;
            alu_op = OP_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_class)
          CL_MULDIV: begin
            ctrl[CB_ZHIGH_OUT] = 1'b1; ctrl[CB_HI_IN] = 1'b1;
          end
          CL_LD: begin
            ctrl[CB_READ] = 1'b1; ctrl[CB_MDR_IN] = 1'b1;
          end
          CL_ST: begin
            ctrl[CB_GRA] = 1'b1; ctrl[CB_R_OUT] = 1'b1; ctrl[CB_MDR_IN] = 1'b1;
          end
          CL_BR: begin
            // Branch target is always computed; only the PC load is conditional
            ctrl[CB_ZLOW_OUT] = 1'b1;
            ctrl[CB_PC_IN]    = con_out;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_class)
          CL_LD: begin
            ctrl[CB_MDR_OUT] = 1'b1; ctrl[CB_GRA] = 1'b1; ctrl[CB_R_IN] = 1'b1;
          end
          CL_ST: ctrl[CB_WRITE] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the DataPath. Owns the T-state
// register, the opcode latch and the memory-wait / stop handling; the strobe
// decode lives in ctrl_decode.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int ALUOP_W  = 5,
  parameter int CTRL_W   = 30,
  parameter bit WAIT_EN  = 1'b1
) (
  input  logic                 clock,
  input  logic                 clear,
  control_sequencer_if.master  bus,
  output state_t               dbg_state
);

  state_t              state;
  state_t              state_next;
  logic [OPCODE_W-1:0] opcode_q;
  op_class_t           op_class;
  logic                mem_wait;
  logic [CTRL_W-1:0]   ctrl_d;
  logic [ALUOP_W-1:0]  alu_d;
  logic                illegal_d;

  assign op_class = classify(opcode_q);

  // T-state register; clear returns to RST from any state, mid-instruction too
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_RST;
    else       state <= state_next;
  end

  // Opcode latch: IR is captured when fetch hands over to execute
  always_ff @(posedge clock or posedge clear) begin
    if (clear)              opcode_q <= '0;
    else if (state == S_T2) opcode_q <= bus.ir_opcode;
  end

  // Memory stall: Read/Write states hold until the access completes
  always_comb begin
    mem_wait = 1'b0;
    if (WAIT_EN && !bus.mem_ready) begin
      case (state)
        S_T1:    mem_wait = 1'b1;
        S_T6:    mem_wait = (op_class == CL_LD);
        S_T7:    mem_wait = (op_class == CL_ST);
        default: mem_wait = 1'b0;
      endcase
    end
  end

  // Next state: stall, halt, instruction boundary or step to the next T-state
  always_comb begin
    state_next = state;
    case (state)
      S_RST:    state_next = S_T0;
      S_HALTED: state_next = S_HALTED;
      default: begin
        if (mem_wait)
          state_next = state;
        else if (state == S_T3 && op_class == CL_HALT)
          state_next = S_HALTED;
        else if (state == last_state(op_class))
          state_next = bus.stop ? S_HALTED : S_T0;
        else
          state_next = state_t'(state + 4'd1);
      end
    endcase
  end

  ctrl_decode u_decode (
    .state   (state),
    .opcode  (opcode_q),
    .con_out (bus.CON_out),
    .ctrl    (ctrl_d),
    .alu_op  (alu_d),
    .illegal (illegal_d)
  );

  assign bus.ctrl    = ctrl_d;
  assign bus.alu_op  = alu_d;
  assign bus.illegal = illegal_d;
  assign bus.run     = (state != S_HALTED);
  assign dbg_state   = state;

endmodule
